// File: rtl/pp_pipeline_accel_rows_fanout.sv
// Forwards the rows scalar to two FIFO channels once per ap_start/ap_done handshake.
// Build option: define PP_ROWS_CLAMP_EN to clamp latched rows to 2160.
module pp_pipeline_accel_rows_fanout (
   input  logic        ap_clk,
   input  logic        ap_rst,
   input  logic        ap_start,
   output logic        ap_done,
   input  logic        ap_continue,
   output logic        ap_idle,
   output logic        ap_ready,
   input  logic [15:0] rows,
   output logic [15:0] rows_out0_din,
   input  logic        rows_out0_full_n,
   output logic        rows_out0_write,
   input  logic [2:0]  rows_out0_num_data_valid,
   input  logic [2:0]  rows_out0_fifo_cap,
   output logic [15:0] rows_out1_din,
   input  logic        rows_out1_full_n,
   output logic        rows_out1_write,
   input  logic [2:0]  rows_out1_num_data_valid,
   input  logic [2:0]  rows_out1_fifo_cap
);

   localparam logic [2:0] ST_IDLE  = 3'b001;
   localparam logic [2:0] ST_WRITE = 3'b010;
   localparam logic [2:0] ST_DONE  = 3'b100;

   logic [2:0]  state_q, state_d;
   logic [15:0] rows_q, rows_d;
   logic [15:0] rows_lat;
   logic [1:0]  pend_q, pend_d;
   logic        done_reg_q, done_reg_d;
   logic [1:0]  full_n;
   logic [1:0]  wr;
   logic        accept;
   logic        unused_fifo_status;

   assign full_n = {rows_out1_full_n, rows_out0_full_n};

   // Occupancy/capacity are informational only; the handshake uses full_n.
   assign unused_fifo_status = ^{rows_out0_num_data_valid, rows_out0_fifo_cap,
                                 rows_out1_num_data_valid, rows_out1_fifo_cap};

`ifdef PP_ROWS_CLAMP_EN
   localparam logic [15:0] ROWS_MAX = 16'd2160;

   // Saturate the incoming row count before it is latched.
   always_comb begin
      rows_lat = rows;
      if (rows > ROWS_MAX) begin
         rows_lat = ROWS_MAX;
      end else begin
         rows_lat = rows;
      end
   end
`else
   assign rows_lat = rows;
`endif

   assign accept = (state_q == ST_IDLE) && ap_start && !done_reg_q;

   // Write strobes: each channel fires independently while still pending.
   always_comb begin
      wr = 2'b00;
      if (state_q == ST_WRITE) begin
         wr = pend_q & full_n;
      end else begin
         wr = 2'b00;
      end
   end

   // Next-state logic for the handshake FSM and its payload.
   always_comb begin
      state_d = state_q;
      rows_d  = rows_q;
      pend_d  = pend_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_WRITE;
               rows_d  = rows_lat;
               pend_d  = 2'b11;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WRITE: begin
            pend_d = pend_q & ~wr;
            if ((pend_q & ~wr) == 2'b00) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_WRITE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            pend_d  = 2'b00;
         end
         default: begin
            state_d = ST_IDLE;
            pend_d  = 2'b00;
         end
      endcase
   end

   // Sticky done: ap_continue acknowledges and wins over a new DONE.
   always_comb begin
      done_reg_d = done_reg_q;
      if (ap_continue) begin
         done_reg_d = 1'b0;
      end else if (state_q == ST_DONE) begin
         done_reg_d = 1'b1;
      end else begin
         done_reg_d = done_reg_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q    <= ST_IDLE;
         rows_q     <= 16'd0;
         pend_q     <= 2'b00;
         done_reg_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rows_q     <= rows_d;
         pend_q     <= pend_d;
         done_reg_q <= done_reg_d;
      end
   end

   assign ap_done         = (state_q == ST_DONE) || done_reg_q;
   assign ap_ready        = (state_q == ST_DONE);
   assign ap_idle         = (state_q == ST_IDLE) && !ap_start;
   assign rows_out0_din   = rows_q;
   assign rows_out1_din   = rows_q;
   assign rows_out0_write = wr[0];
   assign rows_out1_write = wr[1];

endmodule

// File: tb/tb_pp_pipeline_accel_rows_fanout.sv
// Self-checking bench for pp_pipeline_accel_rows_fanout: directed scenarios plus random traffic
// compared against a transaction-level reference model. Honors PP_ROWS_CLAMP_EN.
module tb_pp_pipeline_accel_rows_fanout;

   logic        ap_clk = 1'b0;
   logic        ap_rst = 1'b1;
   logic        ap_start = 1'b0;
   logic        ap_continue = 1'b0;
   logic [15:0] rows = 16'd0;
   logic        full0 = 1'b1;
   logic        full1 = 1'b1;
   logic [2:0]  ndv0 = 3'd0, cap0 = 3'd2, ndv1 = 3'd0, cap1 = 3'd2;
   logic        ap_done, ap_idle, ap_ready;
   logic [15:0] rows_out0_din, rows_out1_din;
   logic        rows_out0_write, rows_out1_write;

   int n_err = 0;
   int n_checks = 0;

   // Reference model: invocation-level bookkeeping.
   bit          m_on = 1'b0;
   bit          m_busy = 1'b0;
   bit          m_done_now = 1'b0;
   bit          m_hold = 1'b0;
   int          m_owe0 = 0, m_owe1 = 0;
   logic [15:0] m_val = 16'd0;
   logic [15:0] exp_q0[$], exp_q1[$], got_q0[$], got_q1[$];

`ifdef PP_ROWS_CLAMP_EN
   localparam logic [15:0] EXP_4000 = 16'd2160;
`else
   localparam logic [15:0] EXP_4000 = 16'd4000;
`endif

   pp_pipeline_accel_rows_fanout dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(ap_done),
      .ap_continue(ap_continue), .ap_idle(ap_idle), .ap_ready(ap_ready), .rows(rows),
      .rows_out0_din(rows_out0_din), .rows_out0_full_n(full0), .rows_out0_write(rows_out0_write),
      .rows_out0_num_data_valid(ndv0), .rows_out0_fifo_cap(cap0),
      .rows_out1_din(rows_out1_din), .rows_out1_full_n(full1), .rows_out1_write(rows_out1_write),
      .rows_out1_num_data_valid(ndv1), .rows_out1_fifo_cap(cap1)
   );

   always #5 ap_clk = ~ap_clk;

   function automatic logic [15:0] lat(input logic [15:0] r);
`ifdef PP_ROWS_CLAMP_EN
      return (r > 16'd2160) ? 16'd2160 : r;
`else
      return r;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Settle after inputs change, log writes, compare against the model.
   task automatic sample();
      logic ew0, ew1;
      #1;
      if (rows_out0_write === 1'b1) got_q0.push_back(rows_out0_din);
      if (rows_out1_write === 1'b1) got_q1.push_back(rows_out1_din);
      if (m_on) begin
         ew0 = m_busy && (m_owe0 > 0) && (full0 === 1'b1);
         ew1 = m_busy && (m_owe1 > 0) && (full1 === 1'b1);
         chk("write0", {31'd0, rows_out0_write}, {31'd0, ew0});
         chk("write1", {31'd0, rows_out1_write}, {31'd0, ew1});
         chk("done",   {31'd0, ap_done},  {31'd0, m_done_now | m_hold});
         chk("ready",  {31'd0, ap_ready}, {31'd0, m_done_now});
         chk("idle",   {31'd0, ap_idle},  {31'd0, !m_busy && !m_done_now && !ap_start});
         chk("din0",   {16'd0, rows_out0_din}, {16'd0, m_val});
         chk("din1",   {16'd0, rows_out1_din}, {16'd0, m_val});
      end
   endtask

   // Advance the model by one clock using the current inputs, then step the DUT.
   task automatic advance();
      bit w0, w1;
      w0 = m_busy && (m_owe0 > 0) && (full0 === 1'b1);
      w1 = m_busy && (m_owe1 > 0) && (full1 === 1'b1);
      if (ap_rst) begin
         if (m_busy && m_owe0 > 0) void'(exp_q0.pop_back());
         if (m_busy && m_owe1 > 0) void'(exp_q1.pop_back());
         m_busy = 1'b0; m_done_now = 1'b0; m_hold = 1'b0;
         m_owe0 = 0; m_owe1 = 0; m_val = 16'd0; m_on = 1'b1;
      end else if (m_done_now) begin
         m_done_now = 1'b0;
         m_hold = !ap_continue;
      end else if (m_busy) begin
         if (w0) m_owe0--;
         if (w1) m_owe1--;
         if (m_owe0 == 0 && m_owe1 == 0) begin
            m_busy = 1'b0;
            m_done_now = 1'b1;
         end
         if (ap_continue) m_hold = 1'b0;
      end else begin
         if (ap_start && !m_hold) begin
            m_busy = 1'b1; m_owe0 = 1; m_owe1 = 1; m_val = lat(rows);
            exp_q0.push_back(lat(rows));
            exp_q1.push_back(lat(rows));
         end
         if (ap_continue) m_hold = 1'b0;
      end
      @(posedge ap_clk);
      @(negedge ap_clk);
   endtask

   task automatic cycle();
      sample();
      advance();
   endtask

   initial begin
      int base;
      // Reset
      cycle(); cycle();
      ap_rst = 1'b0;
      cycle();

      // Both channels ready: writes at N+1, done at N+2
      rows = 16'd1080; ap_start = 1'b1;
      cycle();
      ap_start = 1'b0; rows = 16'd5;
      sample();
      chk("r26_w0", {31'd0, rows_out0_write}, 32'd1);
      chk("r26_w1", {31'd0, rows_out1_write}, 32'd1);
      chk("r26_din", {16'd0, rows_out1_din}, 32'd1080);
      advance();
      sample();
      chk("r26_done", {31'd0, ap_done}, 32'd1);
      advance();
      ap_continue = 1'b1; cycle(); ap_continue = 1'b0;

      // Channel 1 full for five cycles
      rows = 16'd720; ap_start = 1'b1; full1 = 1'b0;
      cycle();
      ap_start = 1'b0;
      sample();
      chk("r27_w0", {31'd0, rows_out0_write}, 32'd1);
      chk("r27_w1", {31'd0, rows_out1_write}, 32'd0);
      advance();
      repeat (4) cycle();
      full1 = 1'b1;
      sample();
      chk("r27_w1_late", {31'd0, rows_out1_write}, 32'd1);
      chk("r27_din", {16'd0, rows_out1_din}, 32'd720);
      advance();
      sample();
      chk("r27_done", {31'd0, ap_done}, 32'd1);
      advance();
      ap_continue = 1'b1; cycle(); ap_continue = 1'b0;

      // Done held without continue; start is ignored
      rows = 16'd300; ap_start = 1'b1;
      cycle(); cycle(); cycle();
      rows = 16'd999;
      repeat (3) begin
         sample();
         chk("r28_hold", {31'd0, ap_done}, 32'd1);
         chk("r28_nowr", {31'd0, rows_out0_write}, 32'd0);
         chk("r28_din", {16'd0, rows_out0_din}, 32'd300);
         advance();
      end
      ap_continue = 1'b1;
      cycle(); cycle();
      ap_start = 1'b0;
      sample();
      chk("r28_next", {16'd0, rows_out0_din}, 32'd999);
      advance();
      cycle();

      // Reset during a stalled WRITE abandons the invocation
      full0 = 1'b0; full1 = 1'b0; rows = 16'd50; ap_start = 1'b1; ap_continue = 1'b0;
      cycle();
      ap_start = 1'b0;
      cycle();
      ap_rst = 1'b1;
      cycle();
      ap_rst = 1'b0; full0 = 1'b1; full1 = 1'b1;
      sample();
      chk("r29_done", {31'd0, ap_done}, 32'd0);
      chk("r29_idle", {31'd0, ap_idle}, 32'd1);
      chk("r29_din",  {16'd0, rows_out0_din}, 32'd0);
      chk("r29_nowr", {31'd0, rows_out0_write | rows_out1_write}, 32'd0);
      advance();

      // Clamp boundary
      rows = 16'd4000; ap_start = 1'b1; ap_continue = 1'b1;
      cycle();
      ap_start = 1'b0;
      sample();
      chk("r30_din", {16'd0, rows_out0_din}, {16'd0, EXP_4000});
      advance();
      cycle();

      // Back-to-back invocations arrive in order
      base = got_q0.size();
      rows = 16'd100; ap_start = 1'b1;
      cycle();
      ap_start = 1'b0;
      cycle(); cycle();
      rows = 16'd200; ap_start = 1'b1;
      cycle();
      ap_start = 1'b0;
      cycle(); cycle();
      chk("r31_cnt", got_q0.size() - base, 32'd2);
      if (got_q0.size() >= base + 2) begin
         chk("r31_a0", {16'd0, got_q0[base]}, 32'd100);
         chk("r31_b0", {16'd0, got_q0[base+1]}, 32'd200);
         chk("r31_a1", {16'd0, got_q1[base]}, 32'd100);
         chk("r31_b1", {16'd0, got_q1[base+1]}, 32'd200);
      end

      // Random traffic against the model
      repeat (800) begin
         ap_rst      = ($urandom_range(0, 79) == 0);
         ap_start    = $urandom_range(0, 1) == 1;
         ap_continue = $urandom_range(0, 2) != 0;
         full0       = $urandom_range(0, 3) != 0;
         full1       = $urandom_range(0, 3) != 0;
         rows        = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 65535));
         cycle();
      end
      ap_rst = 1'b0; ap_start = 1'b0; ap_continue = 1'b1; full0 = 1'b1; full1 = 1'b1;
      repeat (4) cycle();

      // Every accepted invocation written exactly once per channel, in order
      chk("q0_size", got_q0.size(), exp_q0.size());
      chk("q1_size", got_q1.size(), exp_q1.size());
      for (int i = 0; i < exp_q0.size() && i < got_q0.size(); i++)
         chk("q0_data", {16'd0, got_q0[i]}, {16'd0, exp_q0[i]});
      for (int i = 0; i < exp_q1.size() && i < got_q1.size(); i++)
         chk("q1_data", {16'd0, got_q1[i]}, {16'd0, exp_q1[i]});

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
